// File: rtl/mod_addsub_pkg.sv
// Shared constants and FSM encoding for the modular add/sub sequencer.
package mod_addsub_pkg;
  localparam int N       = 1027;
  localparam int ADD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP1  = 3'd1,
    CHK1 = 3'd2,
    OP2  = 3'd3,
    CHK2 = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/mpadder3.sv
// Single-stage carry-select adder/subtractor. The upper half is computed for
// both carry-ins in parallel and selected by the lower-half carry; the sum is
// registered, so inputs in cycle t appear on result in cycle t+1.
// result[N] is the carry-out for add and the borrow for subtract.
module mpadder3 #(
  parameter int N = 1027
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         subtract,
  output logic [N:0]   result
);
  localparam int LO = (N + 1) / 2;
  localparam int HI = N - LO;

  logic [N-1:0] bx;
  logic [LO:0]  lo_sum;
  logic [HI:0]  hi_sum0, hi_sum1, hi_sel;

  // Two's-complement subtract: a + ~b + 1, carry-in feeds the low half.
  always_comb begin
    bx      = subtract ? ~in_b : in_b;
    lo_sum  = {1'b0, in_a[LO-1:0]} + {1'b0, bx[LO-1:0]} + {{LO{1'b0}}, subtract};
    hi_sum0 = {1'b0, in_a[N-1:LO]} + {1'b0, bx[N-1:LO]};
    hi_sum1 = hi_sum0 + {{HI{1'b0}}, 1'b1};
    hi_sel  = lo_sum[LO] ? hi_sum1 : hi_sum0;
  end

  // Register the sum; for subtract the carry-out is inverted into a borrow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) result <= '0;
    else         result <= {hi_sel[HI] ^ subtract, hi_sel[HI-1:0], lo_sum[LO-1:0]};
  end
endmodule

// File: rtl/mod_addsub_ctrl.sv
// (a +/- b) mod M sequencer: a raw pass followed by a correction pass through
// one shared mpadder3 instance. Fixed 6-cycle round trip from start to IDLE.
module mod_addsub_ctrl
  import mod_addsub_pkg::*;
#(
  parameter int N = mod_addsub_pkg::N
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  state_t       state, state_nxt;
  logic [N-1:0] a_r, b_r, m_r, r_r;
  logic         op_r, f_r;
  logic [N-1:0] add_a, add_b;
  logic         add_sub;
  logic [N:0]   add_res;

  mpadder3 #(.N(N)) u_adder (
    .clk      (clk),
    .resetn   (resetn),
    .in_a     (add_a),
    .in_b     (add_b),
    .subtract (add_sub),
    .result   (add_res)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state, status outputs and the state-indexed adder input mux.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = OP1;
      OP1: begin
        busy      = 1'b1;
        add_a     = a_r;
        add_b     = b_r;
        add_sub   = op_r;
        state_nxt = CHK1;
      end
      CHK1: begin
        busy      = 1'b1;
        state_nxt = OP2;
      end
      OP2: begin
        // Add corrects with R-M, subtract corrects with R+M.
        busy      = 1'b1;
        add_a     = r_r;
        add_b     = m_r;
        add_sub   = ~op_r;
        state_nxt = CHK2;
      end
      CHK2: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, raw-pass capture and corrected-result select.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
      op_r   <= 1'b0;
      r_r    <= '0;
      f_r    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r  <= in_a;
          b_r  <= in_b;
          m_r  <= in_m;
          op_r <= subtract;
        end
        CHK1: begin
          r_r <= add_res[N-1:0];
          f_r <= add_res[N];
        end
        CHK2: begin
          // Add keeps R-M unless it borrowed; subtract keeps R+M only if a<b.
          if (op_r) result <= f_r ? add_res[N-1:0] : r_r;
          else      result <= add_res[N] ? r_r : add_res[N-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench: directed literal cases plus randomized operations,
// all compared every cycle against a cycle-count/arithmetic reference model.
module tb_mod_addsub_ctrl;
  import mod_addsub_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0, in_m = '0;
  logic         busy, done;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  mod_addsub_ctrl #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: plain modular add/sub on wide integers.
  function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m, input logic sub);
    logic [N+1:0] t;
    if (!sub) begin
      t = {2'b00, a} + {2'b00, b};
      if (t >= {2'b00, m}) t = t - {2'b00, m};
    end else if (a >= b) t = {2'b00, a} - {2'b00, b};
    else                 t = {2'b00, a} + {2'b00, m} - {2'b00, b};
    return t[N-1:0];
  endfunction

  // Model: cycle index since the accepting edge (0 = idle), pending answer.
  int           cnt = 0;
  logic [N-1:0] pend = '0;
  logic [N-1:0] exp_res = '0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt = 0; exp_res = '0;
    end else if (cnt == 0) begin
      if (start) begin
        cnt = 1;
        pend = ref_mod(in_a, in_b, in_m, subtract);
      end
    end else if (cnt == 5) cnt = 0;
    else begin
      cnt = cnt + 1;
      if (cnt == 5) exp_res = pend;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (busy !== (cnt >= 1 && cnt <= 4)) begin
        errors++; $display("FAIL busy cnt=%0d got %b", cnt, busy);
      end
      checks++;
      if (done !== (cnt == 5)) begin
        errors++; $display("FAIL done cnt=%0d got %b", cnt, done);
      end
      checks++;
      if (result !== exp_res) begin
        errors++;
        $display("FAIL result got ..%h want ..%h", result[127:0], exp_res[127:0]);
      end
      if (done) done_seen++;
    end
  end

  function automatic logic [N-1:0] rnd_wide();
    logic [33*32-1:0] w;
    for (int i = 0; i < 33; i++) w[i*32 +: 32] = $urandom;
    return w[N-1:0];
  endfunction

  task automatic check_lit(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got ..%h want ..%h", name, got[127:0], want[127:0]);
    end
  endtask

  // Issue one op; optionally jam junk starts while busy. Returns cycles to done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] m, input logic sub, input bit noise,
                        output int lat);
    @(negedge clk);
    start = 1'b1; subtract = sub; in_a = a; in_b = b; in_m = m;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      if (noise) begin
        start = 1'($urandom); subtract = 1'($urandom);
        in_a = rnd_wide(); in_b = rnd_wide(); in_m = rnd_wide();
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL timeout waiting for done");
    end
  endtask

  initial begin : stim
    int lat;
    int d0;
    logic [N-1:0] bigm, m, a, b;
    logic sub;

    // Reset state.
    #1;
    check_lit("reset_result", result, '0);
    check_lit("reset_busy", N'(busy), '0);
    check_lit("reset_done", N'(done), '0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Directed cases with hand-computed answers.
    run_op(7, 9, 13, 1'b0, 1'b0, lat);
    check_lit("add_7_9", result, 3);
    check_lit("latency", N'(lat), 5);
    run_op(3, 9, 13, 1'b0, 1'b0, lat);
    check_lit("add_3_9", result, 12);
    run_op(9, 3, 13, 1'b1, 1'b0, lat);
    check_lit("sub_9_3", result, 6);
    run_op(3, 9, 13, 1'b1, 1'b0, lat);
    check_lit("sub_3_9", result, 7);
    run_op(0, 0, 13, 1'b1, 1'b0, lat);
    check_lit("sub_0_0", result, 0);
    bigm = '1; bigm[N-1] = 1'b0;
    run_op(bigm - 1, bigm - 1, bigm, 1'b0, 1'b0, lat);
    check_lit("add_big", result, bigm - 2);
    run_op(0, bigm - 1, bigm, 1'b1, 1'b0, lat);
    check_lit("sub_big", result, 1);

    // Starts in cycles 2 and 5 of an active op are ignored.
    @(negedge clk);
    d0 = done_seen;
    start = 1'b1; subtract = 1'b0; in_a = 7; in_b = 9; in_m = 13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 2 || c == 5);
      subtract = 1'b1; in_a = 3; in_b = 9;
    end
    start = 1'b0;
    check_lit("ignored_starts_done", N'(done_seen - d0), 1);
    check_lit("ignored_starts_res", result, 3);

    // Reset asserted in cycle 3 of an op.
    @(negedge clk);
    start = 1'b1; subtract = 1'b0; in_a = 3; in_b = 9; in_m = 13;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    check_lit("midrst_busy", N'(busy), '0);
    check_lit("midrst_done", N'(done), '0);
    check_lit("midrst_result", result, '0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    d0 = done_seen;
    repeat (8) @(negedge clk);
    check_lit("midrst_no_done", N'(done_seen - d0), 0);
    run_op(9, 3, 13, 1'b1, 1'b0, lat);
    check_lit("after_rst", result, 6);

    // Randomized operations, some with junk starts while busy.
    for (int k = 0; k < 60; k++) begin
      m = rnd_wide(); m[N-1] = 1'b0;
      m = m >> $urandom_range(0, N - 3);
      if (m == 0) m = 1;
      a = rnd_wide() % m;
      b = ($urandom_range(0, 7) == 0) ? a : rnd_wide() % m;
      sub = 1'($urandom);
      run_op(a, b, m, sub, ($urandom_range(0, 2) == 0), lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
